// File: rtl/fetch_stage_if.sv
// Instruction-memory request/valid bus between the fetch stage (master) and memory (slave).
interface fetch_stage_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ADDR_W  = 16
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic [INSTR_W-1:0] rdata;
  logic               valid;

  modport master (
    output req,
    output addr,
    input  rdata,
    input  valid
  );

  modport slave (
    input  req,
    input  addr,
    output rdata,
    output valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register: single-outstanding fetch, stall hold buffer,
// and branch redirect resolved from EX flags.
module fetch_stage #(
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned PC_INC   = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_stage_if.master       imem,
  input  logic                i_stall,
  input  logic [1:0]          i_ex_branch_select,
  input  logic [ADDR_W-1:0]   i_ex_branch_target,
  input  logic                i_ex_set_flags,
  input  logic                i_ex_zero,
  input  logic                i_ex_neg,
  output logic [3:0]          o_opcode,
  output logic [INSTR_W-1:0]  o_ifid_instr,
  output logic [ADDR_W-1:0]   o_ifid_pc,
  output logic                o_ifid_valid,
  output logic                o_flag_z,
  output logic                o_flag_n
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDiscard} state_e;

  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PcInc   = ADDR_W'(PC_INC);

  state_e               r_state, w_state_nxt;
  logic [ADDR_W-1:0]    r_pc, w_pc_nxt;
  logic [ADDR_W-1:0]    r_req_addr, w_req_addr_nxt;
  logic [INSTR_W-1:0]   r_buf, w_buf_nxt;
  logic [INSTR_W-1:0]   r_ifid_instr, w_ifid_instr_nxt;
  logic [ADDR_W-1:0]    r_ifid_pc, w_ifid_pc_nxt;
  logic                 r_ifid_valid, w_ifid_valid_nxt;
  logic                 r_flag_z, r_flag_n;

  logic                 w_eff_z, w_eff_n;
  logic                 w_taken;
  logic                 w_ifid_busy;
  logic                 w_accept;
  logic                 w_load;
  logic [INSTR_W-1:0]   w_load_instr;
  logic [ADDR_W-1:0]    w_seq_addr;

  // Flags produced by the instruction in EX this cycle take precedence over stored ones.
  assign w_eff_z = i_ex_set_flags ? i_ex_zero : r_flag_z;
  assign w_eff_n = i_ex_set_flags ? i_ex_neg  : r_flag_n;

  always_comb begin
    unique case (i_ex_branch_select)
      2'b01:   w_taken = 1'b1;
      2'b10:   w_taken = w_eff_z;
      2'b11:   w_taken = w_eff_n;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_ifid_busy = i_stall & r_ifid_valid;
  assign w_accept    = imem.valid & ~w_ifid_busy;
  assign w_seq_addr  = r_req_addr + PcInc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        w_state_nxt = StFetch;
      end
      StFetch: begin
        if (w_taken) begin
          w_state_nxt = imem.valid ? StFetch : StDiscard;
        end else if (imem.valid && !w_accept) begin
          w_state_nxt = StHold;
        end
      end
      StHold: begin
        if (w_taken || !i_stall) begin
          w_state_nxt = StFetch;
        end
      end
      StDiscard: begin
        if (imem.valid) begin
          w_state_nxt = StFetch;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Datapath next-state: PC, request address, hold buffer, IF/ID register
  always_comb begin
    w_pc_nxt         = r_pc;
    w_req_addr_nxt   = r_req_addr;
    w_buf_nxt        = r_buf;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_valid_nxt = w_ifid_busy;
    w_load           = 1'b0;
    w_load_instr     = imem.rdata;

    unique case (r_state)
      StIdle: begin
        w_req_addr_nxt = r_pc;
      end
      StFetch: begin
        if (w_accept) begin
          w_load = 1'b1;
        end else if (imem.valid) begin
          w_buf_nxt = imem.rdata;
        end
      end
      StHold: begin
        if (!i_stall) begin
          w_load       = 1'b1;
          w_load_instr = r_buf;
        end
      end
      StDiscard: begin
        if (imem.valid) begin
          w_req_addr_nxt = r_pc;
        end
      end
      default: begin
        w_req_addr_nxt = r_pc;
      end
    endcase

    if (w_taken) begin
      w_ifid_valid_nxt = 1'b0;
      w_pc_nxt         = i_ex_branch_target;
      // An outstanding request must complete at its original address before redirecting.
      if (r_state == StDiscard) begin
        w_req_addr_nxt = imem.valid ? i_ex_branch_target : r_req_addr;
      end else if (!(r_state == StFetch && !imem.valid)) begin
        w_req_addr_nxt = i_ex_branch_target;
      end
    end else if (w_load) begin
      w_ifid_instr_nxt = w_load_instr;
      w_ifid_pc_nxt    = r_req_addr;
      w_ifid_valid_nxt = 1'b1;
      w_pc_nxt         = w_seq_addr;
      w_req_addr_nxt   = w_seq_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= ResetPc;
      r_req_addr   <= ResetPc;
      r_buf        <= '0;
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
      r_flag_z     <= 1'b0;
      r_flag_n     <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_buf        <= w_buf_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      if (i_ex_set_flags) begin
        r_flag_z <= i_ex_zero;
        r_flag_n <= i_ex_neg;
      end
    end
  end

  // Output logic
  always_comb begin
    imem.req     = (r_state == StFetch) || (r_state == StDiscard);
    imem.addr    = r_req_addr;
    o_opcode     = r_ifid_valid ? r_ifid_instr[INSTR_W-1 -: 4] : 4'b0000;
    o_ifid_instr = r_ifid_instr;
    o_ifid_pc    = r_ifid_pc;
    o_ifid_valid = r_ifid_valid;
    o_flag_z     = r_flag_z;
    o_flag_n     = r_flag_n;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register feeding the control unit's 4-bit OpCode. It holds the PC and runs a single-outstanding request/valid handshake to instruction memory. It resolves taken branches reported from EX using BranchSelect and the ALU flags, presenting one instruction per cycle to decode, with stall and flush support.

## Interface

- INSTR_W, 32, instruction width; OpCode = IfIdInstr[INSTR_W-1:INSTR_W-4]
- ADDR_W, 16, PC / instruction-address width
- PC_INC, 4, PC increment per instruction
- RESET_PC, 0, PC after reset

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- IMemReq  out  1  fetch request
- IMemAddr  out  ADDR_W  fetch address, stable while IMemReq high and IMemValid low
- IMemRdata  in  INSTR_W  fetched instruction, sampled when IMemValid high
- IMemValid  in  1  data valid; may assert in the request cycle or any later cycle
- Stall  in  1  decode cannot accept; IF/ID holds
- ExBranchSelect  in  2  from EX: 00 none, 01 always, 10 if zero, 11 if negative
- ExBranchTarget  in  ADDR_W  branch target from EX
- ExSetFlags  in  1  EX instruction updates flags
- ExZero, ExNeg  in  1 each  ALU result flags
- OpCode  out  4  to control unit; 0000 (NOP) when IfIdValid low
- IfIdInstr  out  INSTR_W  latched instruction
- IfIdPC  out  ADDR_W  PC of latched instruction
- IfIdValid  out  1  IF/ID holds a live instruction
- FlagZ, FlagN  out  1 each  registered flags

## Operation

- States: IDLE, FETCH, HOLD, DISCARD.
- Effective flags: ExZero/ExNeg when ExSetFlags, else FlagZ/FlagN. FlagZ/FlagN load ExZero/ExNeg on any cycle with ExSetFlags.
- Taken = (ExBranchSelect==01) | (10 & effZ) | (11 & effN).
- ReqAddr register drives IMemAddr. PC tracks the next address to fetch.
- Accept = IMemValid & (!Stall | !IfIdValid).
- IDLE: IMemReq=0. Next cycle goes to FETCH with ReqAddr=PC.
- FETCH: IMemReq=1.
  - On Accept: IF/ID <= {IMemRdata, ReqAddr}, IfIdValid=1, PC and ReqAddr <= ReqAddr+PC_INC. Stay in FETCH (back-to-back).
  - On IMemValid without Accept: buffer the data, go to HOLD.
- HOLD: IMemReq=0. When Stall drops, load IF/ID from the buffer, advance PC/ReqAddr, go to FETCH.
- Taken (highest priority, overrides Stall):
  - IfIdValid <= 0, OpCode forced 0000, HOLD buffer dropped, PC <= ExBranchTarget.
  - In FETCH with IMemValid low that cycle: go to DISCARD.
  - Otherwise: ReqAddr <= ExBranchTarget and go to FETCH.
- DISCARD: IMemReq=1 and IMemAddr keep the old ReqAddr. On IMemValid, drop the data, set ReqAddr <= PC, go to FETCH. A further Taken in DISCARD only updates PC.
- Stall with IfIdValid high freezes IfIdInstr, IfIdPC and IfIdValid.
- PC arithmetic wraps modulo 2^ADDR_W with no error.

## Timing

- Reset (asynchronous, immediate): state IDLE, PC=ReqAddr=RESET_PC, IMemReq=0, IfIdInstr=0, IfIdPC=0, IfIdValid=0, OpCode=0000, FlagZ=FlagN=0.
- First IMemReq at the 2nd rising edge after rst_n deasserts; IMemAddr=RESET_PC.
- Zero-wait memory (IMemValid in the request cycle): IfIdValid rises 1 cycle later. Throughput is 1 instruction/cycle.
- Branch penalty: an instruction in IF/ID at the Taken edge is flushed. The first target instruction reaches IF/ID ≥1 cycle after Taken with zero-wait memory, plus the outstanding-request latency in the DISCARD case.
- IMemAddr never changes while IMemReq is high and IMemValid is low.
- Reset during DISCARD or HOLD returns to IDLE; late IMemValid after reset is ignored while in IDLE.

## Test plan

- Reset, zero-wait memory returning addr>>2 as data: IMemAddr 0,4,8,12 on consecutive cycles; IfIdPC 0,4,8 with IfIdValid=1 from cycle 3.
- 3-cycle memory latency: IMemAddr held at 0 for 3 cycles, one IfId load per 3 cycles, PC advances by 4 only on valid.
- Stall for 2 cycles while IfIdValid=1 and data returns: HOLD entered, IMemReq=0, IfIdInstr unchanged; on release the buffered instruction loads and fetch resumes at the next address.
- ExBranchSelect=10, ExSetFlags=1, ExZero=1, target 0x40, with Stall high: IfIdValid=0 next cycle, next fetch address 0x40, FlagZ=1. Same with ExZero=0: no redirect.
- Taken to 0x80 while request to 0x10 is outstanding (latency 2): DISCARD holds IMemAddr=0x10, the returned data is not loaded, then IMemAddr=0x80.
- PC at 0xFFFC with ADDR_W=16: the next fetch goes to 0x0000. rst_n pulsed mid-DISCARD: all outputs return to reset values immediately.
